// File: rtl/uio_arb_pkg.sv
// Shared definitions for the uio pad-bus arbiter and its helpers.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0. Returns the winner one-hot and as an index.
module rr_picker
  import uio_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    idx      = '0;
    onehot   = '0;
    valid    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (req[cand_idx]) idx = cand_idx;
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit bidirectional uio pad bus. Grants one
// requester at a time for a burst, drives pads for writes, samples them for
// reads, and idles the pads for TURN_CYC cycles whenever direction changes.
//
// Handshake: a requester raises req (with req_dir/req_len valid) and holds it
// for the whole burst. grant is high for every transfer cycle. beat_ack marks
// a completed beat: for writes it is coincident with the beat on the pads, so
// the requester must update wr_data during the cycle it sees beat_ack (the
// next beat is registered at the end of that cycle); for reads it arrives one
// cycle after the pad sample, together with rd_valid/rd_data. Dropping req
// mid-burst ends the burst after the beat in progress (done + aborted).
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LEN_W    = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     wr_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       beat_ack,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     done,
  output logic                     aborted,
  output logic                     busy,
  input  logic [7:0]               uio_in,
  output logic [7:0]               uio_out,
  output logic [7:0]               uio_oe,
  output logic [1:0]               state_dbg
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = idx_w(TURN_CYC);

  arb_state_e           state, state_n;
  logic [IW-1:0]        owner, owner_n;
  logic [NUM_REQ-1:0]   owner_oh, owner_oh_n;
  logic                 dir_q, dir_n;
  logic [LEN_W-1:0]     len_q, len_n;
  logic [LEN_W-1:0]     cnt, cnt_n;
  logic [TW-1:0]        turn_cnt, turn_n;
  logic [IW-1:0]        rr_ptr, rr_n;
  logic                 last_dir, last_dir_n;
  logic                 first_xfer, first_n;

  logic [NUM_REQ-1:0]   grant_n, ack_n;
  logic [7:0]           rd_data_n, uio_out_n, uio_oe_n;
  logic                 rd_valid_n, done_n, aborted_n, busy_n;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  assign state_dbg = state;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so the pads and handshakes come straight from flops.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    owner_oh_n = owner_oh;
    dir_n      = dir_q;
    len_n      = len_q;
    cnt_n      = cnt;
    turn_n     = turn_cnt;
    rr_n       = rr_ptr;
    last_dir_n = last_dir;
    first_n    = first_xfer;
    grant_n    = '0;
    ack_n      = '0;
    rd_data_n  = rd_data;
    rd_valid_n = 1'b0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    uio_out_n  = 8'h00;
    uio_oe_n   = OE_RELEASE;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_n    = pick_idx;
          owner_oh_n = pick_oh;
          dir_n      = req_dir[pick_idx];
          len_n      = req_len[pick_idx*LEN_W +: LEN_W];
          cnt_n      = '0;
          turn_n     = '0;
          if (req_dir[pick_idx] != last_dir || first_xfer) state_n = TURN;
          else                                               state_n = XFER;
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURN_CYC - 1)) state_n = XFER;
        else                                turn_n  = turn_cnt + 1'b1;
      end
      XFER: begin
        // A drop on the final beat is still a normal completion.
        if (cnt == len_q || !req[owner]) begin
          state_n    = IDLE;
          done_n     = 1'b1;
          aborted_n  = (cnt != len_q);
          rr_n       = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          last_dir_n = dir_q;
          first_n    = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        // Read beat: pads are sampled now, acknowledged next cycle.
        if (dir_q == DIR_RD) begin
          rd_data_n  = uio_in;
          rd_valid_n = 1'b1;
          ack_n      = owner_oh;
        end
      end
      default: state_n = IDLE;
    endcase

    // Set up the beat that will be on the bus during the next cycle.
    if (state_n == XFER) begin
      grant_n = owner_oh_n;
      if (dir_n == DIR_WR) begin
        uio_out_n = wr_data[owner_n*8 +: 8];
        uio_oe_n  = OE_DRIVE;
        ack_n     = owner_oh_n;
      end
    end

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; reset releases the pads immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      owner_oh   <= '0;
      dir_q      <= DIR_RD;
      len_q      <= '0;
      cnt        <= '0;
      turn_cnt   <= '0;
      rr_ptr     <= '0;
      last_dir   <= DIR_RD;
      first_xfer <= 1'b1;
      grant      <= '0;
      beat_ack   <= '0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
      uio_out    <= 8'h00;
      uio_oe     <= OE_RELEASE;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      owner_oh   <= owner_oh_n;
      dir_q      <= dir_n;
      len_q      <= len_n;
      cnt        <= cnt_n;
      turn_cnt   <= turn_n;
      rr_ptr     <= rr_n;
      last_dir   <= last_dir_n;
      first_xfer <= first_n;
      grant      <= grant_n;
      beat_ack   <= ack_n;
      rd_data    <= rd_data_n;
      rd_valid   <= rd_valid_n;
      done       <= done_n;
      aborted    <= aborted_n;
      busy       <= busy_n;
      uio_out    <= uio_out_n;
      uio_oe     <= uio_oe_n;
    end
  end

endmodule
